// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants for the YCbCr/RGB colour-space converters. The same
// fixed-point coefficient helper serves both conversion directions.
package ycbcr2rgb_pkg;

  localparam int YCC_LATENCY   = 3;
  localparam int CHROMA_OFFSET = 128;

  // Coefficients are written in millionths so they stay exact integers.
  localparam longint COEF_UNIT = 1000000;
  localparam longint KR_MICRO  = 1402000;
  localparam longint KGB_MICRO = 344136;
  localparam longint KGR_MICRO = 714136;
  localparam longint KB_MICRO  = 1772000;

  function automatic int coef_fixed(input longint coef_micro, input int frac);
    longint scaled;
    scaled = coef_micro * (longint'(1) << frac);
    return int'((scaled + COEF_UNIT / 2) / COEF_UNIT);
  endfunction

endpackage

// File: rtl/ycbcr2rgb_sync_delay.sv
// Clock-enabled shift register that keeps video timing aligned with the
// pixel pipeline. Reset clears every tap.
module sync_delay #(
  parameter int N     = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pipe[i] <= '0;
    end else if (ce) begin
      pipe[0] <= d;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[N-1];

endmodule

// File: rtl/ycbcr2rgb.sv
// BT.601 full-range YCbCr to RGB888 converter, three clock-enabled stages.
// Define YCBCR2RGB_ROUND_EN to round half up instead of truncating.
module ycbcr2rgb
  import ycbcr2rgb_pkg::*;
#(
  parameter int FRAC_BITS = 10,
  parameter int LATENCY   = YCC_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de
);

  localparam int ACC_W = 12 + FRAC_BITS;

  localparam logic signed [ACC_W-1:0] KR  = ACC_W'(coef_fixed(KR_MICRO, FRAC_BITS));
  localparam logic signed [ACC_W-1:0] KGB = ACC_W'(coef_fixed(KGB_MICRO, FRAC_BITS));
  localparam logic signed [ACC_W-1:0] KGR = ACC_W'(coef_fixed(KGR_MICRO, FRAC_BITS));
  localparam logic signed [ACC_W-1:0] KB  = ACC_W'(coef_fixed(KB_MICRO, FRAC_BITS));
  localparam logic signed [8:0]       CHROMA_OFF = 9'(CHROMA_OFFSET);

`ifdef YCBCR2RGB_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC_BITS - 1));
`endif

  generate
    if (LATENCY != YCC_LATENCY) begin : g_bad_latency
      $error("ycbcr2rgb: LATENCY must be 3");
    end
    if (FRAC_BITS < 8 || FRAC_BITS > 12) begin : g_bad_frac
      $error("ycbcr2rgb: FRAC_BITS must be in 8..12");
    end
  endgenerate

  function automatic logic signed [ACC_W-1:0] scale_down(input logic signed [ACC_W-1:0] acc);
`ifdef YCBCR2RGB_ROUND_EN
    return (acc + RND_HALF) >>> FRAC_BITS;
`else
    return acc >>> FRAC_BITS;
`endif
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) return 8'd0;
    if (v > ACC_W'(255)) return 8'hFF;
    return v[7:0];
  endfunction

  logic signed [8:0]       cb_p0, cr_p0;
  logic signed [ACC_W-1:0] y_p0;
  logic signed [ACC_W-1:0] y_p1, pr_p1, pgb_p1, pgr_p1, pb_p1;
  logic [7:0]              r_p2, g_p2, b_p2;
  logic [2:0]              sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cb_p0  <= '0;
      cr_p0  <= '0;
      y_p0   <= '0;
      y_p1   <= '0;
      pr_p1  <= '0;
      pgb_p1 <= '0;
      pgr_p1 <= '0;
      pb_p1  <= '0;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else if (ce) begin
      // stage 1: remove chroma offset, align luma to the coefficient scale
      cb_p0  <= $signed({1'b0, Cb}) - CHROMA_OFF;
      cr_p0  <= $signed({1'b0, Cr}) - CHROMA_OFF;
      y_p0   <= $signed(ACC_W'(Y)) <<< FRAC_BITS;
      // stage 2: chroma products
      y_p1   <= y_p0;
      pr_p1  <= KR  * ACC_W'(cr_p0);
      pgb_p1 <= KGB * ACC_W'(cb_p0);
      pgr_p1 <= KGR * ACC_W'(cr_p0);
      pb_p1  <= KB  * ACC_W'(cb_p0);
      // stage 3: sum, rescale, clamp
      r_p2   <= sat_u8(scale_down(y_p1 + pr_p1));
      g_p2   <= sat_u8(scale_down(y_p1 - pgb_p1 - pgr_p1));
      b_p2   <= sat_u8(scale_down(y_p1 + pb_p1));
    end
  end

  sync_delay #(
    .N     (LATENCY),
    .WIDTH (3)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   ({in_hsync, in_vsync, in_de}),
    .q   (sync_q)
  );

  assign R = r_p2;
  assign G = g_p2;
  assign B = b_p2;
  assign {out_hsync, out_vsync, out_de} = sync_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: stimulus queues expected pixels, a monitor
// pops and compares them whenever out_de is presented on an enabled edge.
module tb_ycbcr2rgb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [7:0] Y = 8'd0, Cb = 8'd128, Cr = 8'd128;
  logic       in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
  logic [7:0] R, G, B;
  logic       out_hsync, out_vsync, out_de;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_ce, mon_rst;

  ycbcr2rgb dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .Y         (Y),
    .Cb        (Cb),
    .Cr        (Cr),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_de     (in_de),
    .R         (R),
    .G         (G),
    .B         (B),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_de    (out_de)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int r, input int g, input int b, input logic hs, input logic vs);
    exp_t e;
    e.r = 8'(r); e.g = 8'(g); e.b = 8'(b); e.hs = hs; e.vs = vs;
    return e;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int rescale(input int acc);
`ifdef YCBCR2RGB_ROUND_EN
    return (acc + 512) >>> 10;
`else
    return acc >>> 10;
`endif
  endfunction

  // Reference conversion with FRAC_BITS=10 coefficients written out literally.
  function automatic exp_t model(input int y, input int cb, input int cr, input logic hs, input logic vs);
    int ys, cbs, crs;
    ys  = y * 1024;
    cbs = cb - 128;
    crs = cr - 128;
    return mk(clamp(rescale(ys + 1436 * crs)),
              clamp(rescale(ys - 352 * cbs - 731 * crs)),
              clamp(rescale(ys + 1815 * cbs)), hs, vs);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input int y, input int cb, input int cr, input logic hs, input logic vs,
                      input logic de, input logic c, input exp_t e);
    @(negedge clk);
    Y = 8'(y); Cb = 8'(cb); Cr = 8'(cr);
    in_hsync = hs; in_vsync = vs; in_de = de; ce = c;
    if (c && de && !rst) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 128, 128, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mon_ce  = ce;
      mon_rst = rst;
      #1;
      if (!mon_rst && mon_ce && out_de) begin
        if (sb.size() == 0) begin
          chk("unexpected_pixel", 32'({R, G, B, out_hsync, out_vsync}), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pixel_rgb_sync", 32'({R, G, B, out_hsync, out_vsync}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [28:0] snap;
    logic        c;
    int          y, cb, cr;

    // Reset with busy inputs: everything must read zero.
    rst = 1'b1;
    step(200, 30, 250, 1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    step(200, 30, 250, 1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    chk("reset_rgb", 32'({R, G, B}), 32'h0);
    chk("reset_sync", 32'({out_hsync, out_vsync, out_de}), 32'h0);
    rst = 1'b0;
    repeat (4) idle();

    // Grey pixel latency: out_de rises on the third enabled edge.
    step(128, 128, 128, 1'b0, 1'b0, 1'b1, 1'b1, mk(128, 128, 128, 0, 0));
    chk("latency_c1", 32'(out_de), 32'd0);
    idle();
    chk("latency_c2", 32'(out_de), 32'd0);
    idle();
    chk("latency_c3", 32'(out_de), 32'd1);

    // Saturation, rounding and assorted directed pixels.
    step(255, 128, 255, 1'b1, 1'b0, 1'b1, 1'b1, mk(255, 164, 255, 1, 0));
    step(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, mk(0, 135, 0, 0, 1));
`ifdef YCBCR2RGB_ROUND_EN
    step(81, 90, 240, 1'b1, 1'b1, 1'b1, 1'b1, mk(238, 14, 14, 1, 1));
`else
    step(81, 90, 240, 1'b1, 1'b1, 1'b1, 1'b1, mk(238, 14, 13, 1, 1));
`endif
    step(128, 255, 128, 1'b0, 1'b0, 1'b1, 1'b1, mk(128, 84, 255, 0, 0));
    step(16, 128, 128, 1'b0, 1'b0, 1'b1, 1'b1, mk(16, 16, 16, 0, 0));
    step(255, 128, 128, 1'b0, 1'b0, 1'b1, 1'b1, mk(255, 255, 255, 0, 0));
    repeat (4) idle();

    // Ten distinct pixels under a random clock-enable pattern.
    for (int i = 0; i < 10; i++) begin
      y  = 20 + i * 23;
      cb = 40 + i * 19;
      cr = 200 - i * 17;
      do begin
        c = 1'($urandom_range(0, 1));
        snap = {R, G, B, out_hsync, out_vsync, out_de, 2'b00};
        step(y, cb, cr, 1'(i), 1'(i == 3), 1'b1, c,
             model(y, cb, cr, 1'(i), 1'(i == 3)));
        if (!c) chk("ce_hold", 32'({R, G, B, out_hsync, out_vsync, out_de}), 32'(snap[28:2]));
      end while (!c);
    end
    repeat (4) idle();

    // Mid-line reset drops in-flight pixels.
    step(100, 60, 180, 1'b0, 1'b0, 1'b1, 1'b1, model(100, 60, 180, 0, 0));
    step(150, 70, 90, 1'b0, 1'b0, 1'b1, 1'b1, model(150, 70, 90, 0, 0));
    sb.delete();
    rst = 1'b1;
    step(180, 200, 50, 1'b1, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    chk("midrst_rgb", 32'({R, G, B}), 32'h0);
    chk("midrst_sync", 32'({out_hsync, out_vsync, out_de}), 32'h0);
    step(60, 160, 100, 1'b1, 1'b0, 1'b1, 1'b1, model(60, 160, 100, 1, 0));
    chk("post_rst_c1", 32'(out_de), 32'd0);
    idle();
    chk("post_rst_c2", 32'(out_de), 32'd0);
    idle();
    chk("post_rst_c3", 32'(out_de), 32'd1);
    repeat (4) idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
